// File: rtl/crypt_sequencer_if.sv
// ============================================================================
// Module   : crypt_sequencer_if
// Brief    : Host byte stream and encryption-stage pins of crypt_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crypt_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_data;
    logic              enc_ack;
    logic [DATA_W-1:0] enc_data;
    logic [DATA_W-1:0] enc_key;
    logic [DATA_W-1:0] enc_dout;
    logic              enc_ready;

    modport master (
        output in_ready, out_valid, out_data, out_last, enc_ack, enc_data, enc_key,
        input  in_valid, in_data, out_ready, enc_dout, enc_ready
    );

    modport slave (
        input  in_ready, out_valid, out_data, out_last, enc_ack, enc_data, enc_key,
        output in_valid, in_data, out_ready, enc_dout, enc_ready
    );
endinterface

`default_nettype wire

// File: rtl/crypt_sequencer.sv
// ============================================================================
// Module   : crypt_sequencer
// Brief    : Feeds a message byte-by-byte with a rotating key through an XOR
//            encryption stage using its Ack/Ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypt_sequencer #(
    parameter int DATA_W    = 8,
    parameter int KEY_DEPTH = 8,
    parameter int TIMEOUT   = 15,
    localparam int KW       = $clog2(KEY_DEPTH),
    localparam int TW       = $clog2(TIMEOUT + 1)
) (
    input  wire logic              Clk,
    input  wire logic              nReset,
    input  wire logic              start,
    input  wire logic [7:0]        msg_len,
    input  wire logic [KW:0]       num_keys,
    input  wire logic              key_we,
    input  wire logic [KW-1:0]     key_addr,
    input  wire logic [DATA_W-1:0] key_wdata,
    crypt_sequencer_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ACK  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state;
    logic [7:0]        len;
    logic [7:0]        bcnt;
    logic [KW-1:0]     kidx;
    logic [KW-1:0]     klast;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] ring [KEY_DEPTH];

    // Key ring has no reset; writes are locked out for the whole message.
    always_ff @(posedge Clk) begin
        if (key_we && !busy) begin
            ring[key_addr] <= key_wdata;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state         <= S_IDLE;
            len           <= '0;
            bcnt          <= '0;
            kidx          <= '0;
            klast         <= '0;
            tcnt          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.enc_ack   <= 1'b0;
            bus.enc_data  <= '0;
            bus.enc_key   <= '0;
        end else begin
            done        <= 1'b0;
            bus.enc_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        timeout_err <= 1'b0;
                        len         <= msg_len;
                        klast       <= (num_keys == '0) ? '0 : KW'(num_keys - 1'b1);
                        bcnt        <= '0;
                        kidx        <= '0;
                        tcnt        <= '0;
                        busy        <= 1'b1;
                        if (msg_len == 8'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            bus.in_ready <= 1'b1;
                            state        <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        bus.enc_data <= bus.in_data;
                        bus.enc_key  <= ring[kidx];
                        bus.in_ready <= 1'b0;
                        bus.enc_ack  <= 1'b1;
                        state        <= S_ACK;
                    end
                end
                S_ACK: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving on the final allowed cycle still wins.
                    if (bus.enc_ready) begin
                        bus.out_data  <= bus.enc_dout;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (bcnt == len - 8'd1);
                        state         <= S_OUT;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bcnt          <= bcnt + 8'd1;
                        kidx          <= (kidx == klast) ? '0 : kidx + 1'b1;
                        if (bus.out_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            bus.in_ready <= 1'b1;
                            state        <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    bus.in_ready <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crypt_sequencer.sv
// ============================================================================
// Module   : tb_crypt_sequencer
// Brief    : Self-checking bench for crypt_sequencer with an XOR stage model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crypt_sequencer;

    logic       Clk = 1'b0;
    logic       nReset;
    logic       start;
    logic [7:0] msg_len;
    logic [3:0] num_keys;
    logic       key_we;
    logic [2:0] key_addr;
    logic [7:0] key_wdata;
    logic       busy, done, timeout_err;

    crypt_sequencer_if #(.DATA_W(8)) bus ();

    crypt_sequencer #(.DATA_W(8), .KEY_DEPTH(8), .TIMEOUT(15)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .start      (start),
        .msg_len    (msg_len),
        .num_keys   (num_keys),
        .key_we     (key_we),
        .key_addr   (key_addr),
        .key_wdata  (key_wdata),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    int         enc_delay = 2;
    int         enc_cnt   = 0;
    int         sink_mode = 0;
    bit         src_rand  = 1'b0;
    bit         src_pend  = 1'b0;
    logic [7:0] src_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] ring_m [8];

    typedef struct {
        int              nk;
        int              len;
        logic [2:0][7:0] keys;
        logic [7:0][7:0] din;
        logic [7:0][7:0] dexp;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.enc_ack,
                bus.enc_data, bus.enc_key, busy, done, timeout_err};
    endfunction

    // Encryption stage: drops Ready on Ack, returns DataIn^key enc_delay cycles later.
    always @(posedge Clk) begin
        if (bus.enc_ack) begin
            bus.enc_ready <= 1'b0;
            enc_cnt       <= enc_delay;
        end else if (enc_cnt > 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) begin
                bus.enc_ready <= 1'b1;
                bus.enc_dout  <= bus.enc_data ^ bus.enc_key;
            end
        end
    end

    // Byte source, byte sink and output scoreboard, all on the falling edge.
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge Clk);
            if (done) done_cnt++;
            if (src_pend && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && (!src_rand || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = src_q[0];
            end else begin
                bus.in_valid = 1'b0;
            end
            src_pend = bus.in_valid && bus.in_ready;
            bus.out_ready = (sink_mode == 0) ? 1'b1 :
                            (sink_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e[7:0]);
                    check("out_last", bus.out_last, e[8]);
                end
            end
        end
    end

    task automatic write_key(input int a, input logic [7:0] v);
        tick();
        key_we    = 1'b1;
        key_addr  = a[2:0];
        key_wdata = v;
        tick();
        key_we    = 1'b0;
        ring_m[a] = v;
    endtask

    task automatic start_msg(input int nk, input int len, input logic [15:0][7:0] din,
                             input logic [15:0][7:0] dexp, input bit push_exp);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_wait_timeout", busy, 0);
        for (int i = 0; i < len; i++) begin
            src_q.push_back(din[i]);
            if (push_exp) exp_q.push_back({1'(i == len - 1), dexp[i]});
        end
        tick();
        start    = 1'b1;
        msg_len  = len[7:0];
        num_keys = nk[3:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
        repeat (2) @(negedge Clk);
        check("done_pulses", done_cnt, target);
        check("exp_drained", exp_q.size(), 0);
        check("src_drained", src_q.size(), 0);
    endtask

    function automatic logic [15:0][7:0] model(input int nk, input int len,
                                                input logic [15:0][7:0] din);
        logic [15:0][7:0] r = '0;
        int nke = (nk == 0) ? 1 : nk;
        for (int i = 0; i < len; i++) r[i] = din[i] ^ ring_m[i % nke];
        return r;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        logic [15:0][7:0] din, dexp;

        tbl[0] = '{nk: 2, len: 3, keys: {8'h00, 8'hFF, 8'h5A},
                   din: {8'hA5, 8'h0F, 8'h00}, dexp: {8'hFF, 8'hF0, 8'h5A}};
        tbl[1] = '{nk: 3, len: 7, keys: {8'h03, 8'h02, 8'h01}, din: '0,
                   dexp: {8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01}};
        tbl[2] = '{nk: 0, len: 2, keys: {8'h00, 8'h00, 8'h3C},
                   din: {8'hFF, 8'h11}, dexp: {8'hC3, 8'h2D}};
        tbl[3] = '{nk: 1, len: 1, keys: {8'h00, 8'h00, 8'h80},
                   din: {8'h7F}, dexp: {8'hFF}};

        nReset = 1'b0; start = 1'b0; msg_len = '0; num_keys = '0;
        key_we = 1'b0; key_addr = '0; key_wdata = '0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", all_outs(), 0);
        tick();
        nReset = 1'b1;

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) write_key(k, tbl[t].keys[k]);
            d0 = done_cnt;
            start_msg(tbl[t].nk, tbl[t].len, 16'(0) | tbl[t].din, 16'(0) | tbl[t].dexp, 1'b1);
            wait_done(d0 + 1);
        end

        // Zero-length message: straight to DONE.
        d0 = done_cnt;
        start_msg(1, 0, '0, '0, 1'b0);
        @(negedge Clk);
        check("len0_done", done, 1);
        check("len0_quiet", {bus.in_ready, bus.enc_ack, bus.out_valid}, 0);
        @(negedge Clk);
        check("len0_done_fall", {done, busy}, 0);
        check("len0_pulses", done_cnt - d0 + 1, 2);

        // Stage never answers: abort after ACK + 15 WAIT cycles.
        enc_delay = 0;
        d0 = done_cnt;
        start_msg(1, 3, 128'h030201, '0, 1'b0);
        n = 0;
        while (!bus.enc_ack && n < 50) begin @(negedge Clk); n++; end
        check("to_ack_seen", bus.enc_ack, 1);
        n = 0;
        while (!done && n < 40) begin @(negedge Clk); n++; end
        check("to_cycles", n, 16);
        check("to_err_set", timeout_err, 1);
        tick();
        src_q.delete();
        repeat (3) @(negedge Clk);
        check("to_err_sticky", timeout_err, 1);
        check("to_pulses", done_cnt - d0, 1);
        enc_delay = 2;
        d0 = done_cnt;
        din = 128'h44;
        start_msg(1, 1, din, model(1, 1, din), 1'b1);
        @(negedge Clk);
        check("to_err_cleared", timeout_err, 0);
        wait_done(d0 + 1);

        // Consumer stalls in OUT; key write and start during busy are ignored.
        write_key(0, 8'h33);
        sink_mode = 2;
        d0 = done_cnt;
        start_msg(1, 2, 128'hF00F, 128'hC33C, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge Clk); n++; end
        tick();
        key_we = 1'b1; key_addr = 3'd0; key_wdata = 8'hAA;
        start = 1'b1; msg_len = 8'd0;
        tick();
        key_we = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("stall_hold", {bus.out_valid, bus.out_data, bus.in_ready, bus.enc_ack},
                  {1'b1, 8'h3C, 1'b0, 1'b0});
        end
        sink_mode = 0;
        wait_done(d0 + 1);

        // Asynchronous reset while waiting on the stage.
        enc_delay = 0;
        start_msg(1, 2, 128'h5566, '0, 1'b0);
        n = 0;
        while (!bus.enc_ack && n < 50) begin @(negedge Clk); n++; end
        repeat (2) @(negedge Clk);
        nReset = 1'b0;
        #1;
        check("midreset_outputs", all_outs(), 0);
        src_q.delete();
        exp_q.delete();
        src_pend = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
        enc_delay = 2;
        write_key(1, 8'h0C);
        d0 = done_cnt;
        din = 128'h907050;
        start_msg(2, 3, din, model(2, 3, din), 1'b1);
        wait_done(d0 + 1);

        // Randomized messages against the reference model.
        sink_mode = 1;
        src_rand  = 1'b1;
        for (int r = 0; r < 20; r++) begin
            int nk, len;
            if (r % 4 == 0)
                for (int k = 0; k < 8; k++) write_key(k, 8'($urandom));
            nk  = $urandom_range(0, 8);
            len = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) din[i] = 8'($urandom);
            enc_delay = $urandom_range(1, 4);
            d0 = done_cnt;
            start_msg(nk, len, din, model(nk, len, din), 1'b1);
            wait_done(d0 + 1);
        end
        sink_mode = 0;
        src_rand  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
